ysyx_210247_wb_stage: RTL

// - Write-back stage; consumer end of the MEM->WB valid/allow handshake and of mem_to_wb_bus.
// - Registers one instruction per handshake and retires it:
//   - GPR write, CSR write, difftest commit pulse.
// - Sequences traps (mepc/mcause save, redirect to mtvec) and mret (redirect to mepc).
// - Drives the pipeline flush on each redirect.

---
 rtl/ysyx_210247_wb_stage_pkg.sv | 51 +++++
 rtl/ysyx_210247_wb_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ysyx_210247_wb_stage_pkg.sv
// Shared definitions for the write-back stage:
//   - data width, MEM->WB bus width and field offsets
//   - packed view of the bus (field order matches the bit layout, MSB first)
//   - exc_op bit indices, trap CSR addresses, FSM state encoding
package ysyx_210247_wb_stage_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned BUS_W = 403;

   // Low bit of each field in mem_to_wb_bus
   localparam int unsigned OffWdata    = 0;
   localparam int unsigned OffWdest    = 64;
   localparam int unsigned OffWen      = 69;
   localparam int unsigned OffInst     = 70;
   localparam int unsigned OffPc       = 102;
   localparam int unsigned OffCsrWdata = 166;
   localparam int unsigned OffCsrWaddr = 230;
   localparam int unsigned OffCsrWen   = 242;
   localparam int unsigned OffExcOp    = 243;
   localparam int unsigned OffExcAddr  = 275;
   localparam int unsigned OffExcType  = 339;

   localparam int unsigned ExcOpEcall = 0;
   localparam int unsigned ExcOpMret  = 1;

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;

   typedef struct packed {
      logic [XLEN-1:0] exc_type;
      logic [XLEN-1:0] exc_addr;
      logic [31:0]     exc_op;
      logic            csr_wen;
      logic [11:0]     csr_waddr;
      logic [XLEN-1:0] csr_wdata;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [4:0]      wdest;
      logic [XLEN-1:0] wdata;
   } wb_bus_t;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StTEpc   = 3'd1,
      StTCause = 3'd2,
      StTJump  = 3'd3,
      StMret   = 3'd4
   } wb_state_e;

endpackage

// File: rtl/ysyx_210247_wb_stage.sv
// Write-back stage. Consumes the MEM->WB valid/allow handshake, holds one
// instruction and retires it (GPR write, CSR write, commit pulse). Traps walk
// through mepc save, mcause save and a redirect to mtvec; mret redirects to mepc.
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   mem_valid_out/wb_allow_in/mem_to_wb_bus   MEM->WB handshake and payload
//   rf_*                   GPR write port
//   csr_*_o                single CSR write port
//   mtvec_i, mepc_i        current trap vector and exception pc
//   flush_o, redirect_pc_o one-cycle pipeline kill and new fetch pc
//   WB_wdest, WB_result    hazard/forwarding view of the held instruction
//   commit_*               one pulse per retired instruction
module ysyx_210247_wb_stage
   import ysyx_210247_wb_stage_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             mem_valid_out,
   output logic             wb_allow_in,
   input  logic [BUS_W-1:0] mem_to_wb_bus,
   output logic             rf_wen,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             csr_wen_o,
   output logic [11:0]      csr_waddr_o,
   output logic [XLEN-1:0]  csr_wdata_o,
   input  logic [XLEN-1:0]  mtvec_i,
   input  logic [XLEN-1:0]  mepc_i,
   output logic             flush_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [4:0]       WB_wdest,
   output logic [XLEN-1:0]  WB_result,
   output logic             commit_valid,
   output logic [XLEN-1:0]  commit_pc,
   output logic [31:0]      commit_inst
);

   wb_bus_t   bus_q;
   logic      wb_valid_q;
   wb_state_e state_q;

   logic trap, mret, wb_ready_go, accept, redirect;

   // exc_addr and the upper exc_op bits are carried but not consumed here
   logic unused_bits;
   assign unused_bits = ^{bus_q.exc_addr, bus_q.exc_op[31:2], bus_q.exc_op[ExcOpEcall]};

   assign mret        = bus_q.exc_op[ExcOpMret];
   assign trap        = (bus_q.exc_type != '0) && !mret;
   assign wb_ready_go = wb_valid_q && (state_q == StIdle) && !trap && !mret;
   assign wb_allow_in = (state_q == StIdle) && (!wb_valid_q || wb_ready_go);
   assign accept      = mem_valid_out && wb_allow_in;
   assign redirect    = (state_q == StTJump) || (state_q == StMret);

   always_ff @(posedge clock) begin
      if (reset) begin
         bus_q      <= '0;
         wb_valid_q <= 1'b0;
         state_q    <= StIdle;
      end else begin
         if (accept) begin
            bus_q      <= wb_bus_t'(mem_to_wb_bus);
            wb_valid_q <= 1'b1;
         end else if (wb_ready_go || redirect) begin
            wb_valid_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (wb_valid_q && trap)      state_q <= StTEpc;
               else if (wb_valid_q && mret) state_q <= StMret;
            end
            StTEpc:   state_q <= StTCause;
            StTCause: state_q <= StTJump;
            StTJump:  state_q <= StIdle;
            StMret:   state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   assign rf_wen   = wb_ready_go && bus_q.wen && (bus_q.wdest != 5'd0);
   assign rf_waddr = bus_q.wdest;
   assign rf_wdata = bus_q.wdata;

   // The trapping instruction's own CSR write is dropped; the port carries the
   // mepc/mcause saves instead.
   always_comb begin
      csr_wen_o   = 1'b0;
      csr_waddr_o = bus_q.csr_waddr;
      csr_wdata_o = bus_q.csr_wdata;
      unique case (state_q)
         StTEpc: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = bus_q.pc;
         end
         StTCause: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = bus_q.exc_type;
         end
         default: csr_wen_o = wb_ready_go && bus_q.csr_wen;
      endcase
   end

   always_comb begin
      flush_o       = 1'b0;
      redirect_pc_o = '0;
      if (state_q == StTJump) begin
         flush_o       = 1'b1;
         redirect_pc_o = mtvec_i;
      end else if (state_q == StMret) begin
         flush_o       = 1'b1;
         redirect_pc_o = mepc_i;
      end
   end

   assign WB_wdest     = bus_q.wdest & {5{wb_valid_q}};
   assign WB_result    = bus_q.wdata;
   assign commit_valid = wb_ready_go || redirect;
   assign commit_pc    = bus_q.pc;
   assign commit_inst  = bus_q.inst;

endmodule
